// File: rtl/test_spi_subordinate_multimode.sv
// SPI subordinate bus-functional model: any CPOL/CPHA, configurable word width and bit order.
// Echoes each received word on the following word and buffers received words in an RX FIFO.
module test_spi_subordinate_multimode #(
    parameter int unsigned           WORD_WIDTH     = 8,
    parameter bit                    CPOL           = 1'b0,
    parameter bit                    CPHA           = 1'b0,
    parameter bit                    MSB_FIRST      = 1'b1,
    parameter int unsigned           RX_FIFO_DEPTH  = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_RESPONSE = '0
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            sclk,
    input  logic                            mosi,
    input  logic                            cs,
    output logic                            miso,
    output logic [WORD_WIDTH-1:0]           rx_data,
    output logic                            rx_valid,
    input  logic                            rx_pop,
    output logic                            rx_overflow,
    output logic                            frame_abort,
    output logic [$clog2(RX_FIFO_DEPTH):0]  rx_level
);
    localparam int unsigned WW = WORD_WIDTH;
    localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(WORD_WIDTH + 1);

    logic          sclk_prev_q, cs_prev_q;
    logic          overflow_q, abort_q, tx_bit_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] rx_shift_q, rx_shift_d;
    logic [WW-1:0] echo_q, echo_d;
    logic [WW-1:0] tx_shift_q, tx_shift_d;
    logic [WW-1:0] rx_next, tx_next;
    logic          tx_out;
    logic [WW-1:0] mem_q [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    logic active, cs_fall, cs_rise, lead_edge, trail_edge;
    logic sample_edge, shift_edge, word_done, full, push, pop;

    // Edges are ignored while cs is high and in the cycle cs falls.
    assign cs_fall     = cs_prev_q & ~cs;
    assign cs_rise     = ~cs_prev_q & cs;
    assign active      = ~cs & ~cs_prev_q;
    assign lead_edge   = active & (sclk_prev_q == CPOL) & (sclk != CPOL);
    assign trail_edge  = active & (sclk_prev_q != CPOL) & (sclk == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign word_done   = sample_edge & (cnt_q == CW'(WORD_WIDTH - 1));

    assign full  = (level_q == LW'(RX_FIFO_DEPTH));
    assign pop   = rx_pop & (level_q != '0);
    assign push  = word_done & (~full | pop);

    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_valid    = (level_q != '0);
    assign rx_level    = level_q;
    assign rx_overflow = overflow_q;
    assign frame_abort = abort_q;
    assign miso        = cs ? 1'bz : tx_bit_q;

    // Bit-order dependent shift paths.
    always_comb begin
        rx_next = rx_shift_q;
        tx_next = tx_shift_q;
        tx_out  = 1'b0;
        if (MSB_FIRST) begin
            rx_next = {rx_shift_q[WW-2:0], mosi};
            tx_next = {tx_shift_q[WW-2:0], 1'b0};
            tx_out  = tx_shift_q[WW-1];
        end else begin
            rx_next = {mosi, rx_shift_q[WW-1:1]};
            tx_next = {1'b0, tx_shift_q[WW-1:1]};
            tx_out  = tx_shift_q[0];
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        echo_d     = echo_q;
        tx_shift_d = tx_shift_q;
        if (sample_edge) begin
            rx_shift_d = rx_next;
            if (word_done) begin
                cnt_d  = '0;
                echo_d = rx_next;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (cs_rise) begin
            cnt_d = '0;
        end
        // CPHA=0 preloads the first bit; the shift edge right after a completed word is skipped.
        if (!CPHA) begin
            if (cs_fall) begin
                tx_shift_d = echo_q;
            end else if (word_done) begin
                tx_shift_d = rx_next;
            end else if (shift_edge && (cnt_q != '0)) begin
                tx_shift_d = tx_next;
            end
        end else if (shift_edge) begin
            tx_shift_d = (cnt_q == '0) ? echo_q : tx_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            echo_q      <= RESET_RESPONSE;
            tx_shift_q  <= '0;
            abort_q     <= 1'b0;
        end else begin
            sclk_prev_q <= sclk;
            cs_prev_q   <= cs;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            echo_q      <= echo_d;
            tx_shift_q  <= tx_shift_d;
            abort_q     <= cs_rise & (cnt_q != '0);
        end
    end

    // RX FIFO: a push into a full FIFO is accepted only alongside a pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rx_next;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
            if (word_done && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // miso launches on the falling clock so it is settled well before the next sample.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_bit_q <= 1'b0;
        end else begin
            tx_bit_q <= tx_out;
        end
    end

endmodule

// File: tb/tb_test_spi_subordinate_multimode.sv
// Directed bench for the SPI subordinate model: four instances cover modes 0/1/3 and a 16-bit LSB-first build.
module tb_test_spi_subordinate_multimode;

    logic        clk;
    logic        reset_n;
    logic        sclk [4];
    logic        mosi [4];
    logic        cs   [4];
    logic        pop  [4];
    logic        miso0, miso1, miso2, miso3;
    logic [7:0]  rxd  [3];
    logic [15:0] rxd3;
    logic        vld  [4];
    logic        ovf  [4];
    logic        abrt [4];
    logic [2:0]  lvl  [4];

    int n_vec  = 0;
    int n_fail = 0;
    int abort_cnt = 0;

    typedef struct {
        int          dut;
        bit          sof;
        bit          eof;
        logic [15:0] wd;
        int          nb;
        bit          chk_m;
        logic [15:0] exp_m;
        int          lvl_e;
    } vec_t;

    vec_t vecs [8];

    test_spi_subordinate_multimode #(.WORD_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
        .RX_FIFO_DEPTH(4), .RESET_RESPONSE(8'h00)) u_m0 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk[0]), .mosi(mosi[0]), .cs(cs[0]), .miso(miso0),
        .rx_data(rxd[0]), .rx_valid(vld[0]), .rx_pop(pop[0]), .rx_overflow(ovf[0]),
        .frame_abort(abrt[0]), .rx_level(lvl[0]));

    test_spi_subordinate_multimode #(.WORD_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1),
        .RX_FIFO_DEPTH(4), .RESET_RESPONSE(8'hC3)) u_m3 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk[1]), .mosi(mosi[1]), .cs(cs[1]), .miso(miso1),
        .rx_data(rxd[1]), .rx_valid(vld[1]), .rx_pop(pop[1]), .rx_overflow(ovf[1]),
        .frame_abort(abrt[1]), .rx_level(lvl[1]));

    test_spi_subordinate_multimode #(.WORD_WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1),
        .RX_FIFO_DEPTH(4), .RESET_RESPONSE(8'h00)) u_m1 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk[2]), .mosi(mosi[2]), .cs(cs[2]), .miso(miso2),
        .rx_data(rxd[2]), .rx_valid(vld[2]), .rx_pop(pop[2]), .rx_overflow(ovf[2]),
        .frame_abort(abrt[2]), .rx_level(lvl[2]));

    test_spi_subordinate_multimode #(.WORD_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0),
        .RX_FIFO_DEPTH(4), .RESET_RESPONSE(16'h0000)) u_w16 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk[3]), .mosi(mosi[3]), .cs(cs[3]), .miso(miso3),
        .rx_data(rxd3), .rx_valid(vld[3]), .rx_pop(pop[3]), .rx_overflow(ovf[3]),
        .frame_abort(abrt[3]), .rx_level(lvl[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with frame_abort high on the mode-0 instance.
    always @(posedge clk) begin
        if (abrt[0] === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    function automatic logic get_miso(input int d);
        case (d)
            0:       return miso0;
            1:       return miso1;
            2:       return miso2;
            default: return miso3;
        endcase
    endfunction

    function automatic logic [15:0] get_rx(input int d);
        if (d == 3) return rxd3;
        return 16'(rxd[d]);
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cs_lo(input int d);
        cs[d] = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_hi(input int d);
        cs[d] = 1'b1;
        clk_wait(4);
    endtask

    // Manager side of one word; miso is captured on the manager's sample edge.
    task automatic spi_word(input int d, input logic [15:0] w, input int nb, input bit pop_last,
                            output logic [15:0] got);
        int wd;
        bit msb, cpol, cpha;
        wd   = (d == 3) ? 16 : 8;
        msb  = (d != 3);
        cpol = (d == 1);
        cpha = (d == 1) || (d == 2);
        got  = '0;
        for (int i = 0; i < nb; i++) begin
            int idx;
            idx = msb ? (wd - 1 - i) : i;
            if (!cpha) begin
                mosi[d] = w[idx];
                clk_wait(4);
                got[idx] = get_miso(d);
                sclk[d] = ~cpol;
                if (pop_last && (i == nb - 1)) begin
                    pop[d] = 1'b1;
                    clk_wait(1);
                    pop[d] = 1'b0;
                    clk_wait(3);
                end else begin
                    clk_wait(4);
                end
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = w[idx];
                clk_wait(4);
                got[idx] = get_miso(d);
                sclk[d] = cpol;
                clk_wait(4);
            end
        end
        if (!cpha) clk_wait(4);
    endtask

    task automatic pop_chk(input int d, input logic [15:0] e, input string nm);
        chk({nm, "_data"}, 32'(get_rx(d)), 32'(e));
        chk({nm, "_valid"}, 32'(vld[d]), 32'd1);
        pop[d] = 1'b1;
        clk_wait(1);
        pop[d] = 1'b0;
    endtask

    initial begin
        logic [15:0] got;

        vecs[0] = '{0, 1'b1, 1'b0, 16'h00A5,  8, 1'b1, 16'h0000, 1};
        vecs[1] = '{0, 1'b0, 1'b1, 16'h003C,  8, 1'b1, 16'h00A5, 2};
        vecs[2] = '{1, 1'b1, 1'b0, 16'h0081,  8, 1'b1, 16'h00C3, 1};
        vecs[3] = '{1, 1'b0, 1'b1, 16'h0081,  8, 1'b1, 16'h0081, 2};
        vecs[4] = '{2, 1'b1, 1'b0, 16'h0081,  8, 1'b1, 16'h0000, 1};
        vecs[5] = '{2, 1'b0, 1'b1, 16'h0081,  8, 1'b1, 16'h0081, 2};
        vecs[6] = '{3, 1'b1, 1'b0, 16'h1234, 16, 1'b1, 16'h0000, 1};
        vecs[7] = '{3, 1'b0, 1'b1, 16'hBEEF, 16, 1'b1, 16'h1234, 2};

        reset_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            cs[d]   = 1'b1;
            mosi[d] = 1'b0;
            pop[d]  = 1'b0;
            sclk[d] = (d == 1);
        end
        clk_wait(3);
        chk("rst_level", 32'(lvl[0]), 32'd0);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_ovf",   32'(ovf[0]), 32'd0);
        chk("rst_abort", 32'(abrt[0]), 32'd0);
        chk("rst_data",  32'(rxd[0]), 32'd0);
        reset_n = 1'b1;
        clk_wait(2);

        // Modes 0/3/1 and 16-bit LSB-first transfers.
        for (int k = 0; k < 8; k++) begin
            if (vecs[k].sof) cs_lo(vecs[k].dut);
            spi_word(vecs[k].dut, vecs[k].wd, vecs[k].nb, 1'b0, got);
            if (vecs[k].chk_m) chk($sformatf("vec%0d_miso", k), 32'(got), 32'(vecs[k].exp_m));
            chk($sformatf("vec%0d_level", k), 32'(lvl[vecs[k].dut]), 32'(vecs[k].lvl_e));
            if (vecs[k].eof) cs_hi(vecs[k].dut);
        end
        pop_chk(0, 16'h00A5, "m0_q0");
        pop_chk(0, 16'h003C, "m0_q1");
        chk("m0_drained", 32'(lvl[0]), 32'd0);
        pop_chk(1, 16'h0081, "m3_q0");
        pop_chk(1, 16'h0081, "m3_q1");
        pop_chk(2, 16'h0081, "m1_q0");
        pop_chk(2, 16'h0081, "m1_q1");
        pop_chk(3, 16'h1234, "w16_q0");
        pop_chk(3, 16'hBEEF, "w16_q1");

        // Aborted frame after 5 bits, then a clean word.
        cs_lo(0);
        spi_word(0, 16'h00FF, 5, 1'b0, got);
        cs_hi(0);
        chk("abort_pulse", 32'(abort_cnt), 32'd1);
        chk("abort_level", 32'(lvl[0]), 32'd0);
        cs_lo(0);
        spi_word(0, 16'h0055, 8, 1'b0, got);
        chk("abort_echo", 32'(got), 32'h3C);
        cs_hi(0);
        chk("no_abort_full", 32'(abort_cnt), 32'd1);
        chk("post_abort_lvl", 32'(lvl[0]), 32'd1);
        pop_chk(0, 16'h0055, "post_abort");

        // Overflow, then simultaneous push and pop while full.
        cs_lo(0);
        for (int k = 1; k <= 5; k++) begin
            spi_word(0, 16'(k), 8, 1'b0, got);
            if (k == 1) chk("ovf_echo", 32'(got), 32'h55);
            if (k == 4) chk("ovf_early", 32'(ovf[0]), 32'd0);
            chk($sformatf("ovf_lvl%0d", k), 32'(lvl[0]), (k > 4) ? 32'd4 : 32'(k));
        end
        cs_hi(0);
        chk("ovf_flag", 32'(ovf[0]), 32'd1);
        chk("ovf_head", 32'(rxd[0]), 32'h01);
        cs_lo(0);
        spi_word(0, 16'h0006, 8, 1'b1, got);
        cs_hi(0);
        chk("full_pp_lvl", 32'(lvl[0]), 32'd4);
        chk("ovf_sticky", 32'(ovf[0]), 32'd1);
        pop_chk(0, 16'h0002, "full_q0");
        pop_chk(0, 16'h0003, "full_q1");
        pop_chk(0, 16'h0004, "full_q2");
        pop_chk(0, 16'h0006, "full_q3");
        pop[0] = 1'b1;
        clk_wait(1);
        pop[0] = 1'b0;
        chk("empty_pop_lvl", 32'(lvl[0]), 32'd0);
        chk("empty_pop_vld", 32'(vld[0]), 32'd0);

        // Asynchronous reset mid-word.
        cs_lo(0);
        spi_word(0, 16'h0077, 8, 1'b0, got);
        cs_hi(0);
        chk("pre_rst_lvl", 32'(lvl[0]), 32'd1);
        cs_lo(0);
        spi_word(0, 16'h00F0, 3, 1'b0, got);
        reset_n = 1'b0;
        #2;
        chk("arst_lvl",  32'(lvl[0]), 32'd0);
        chk("arst_vld",  32'(vld[0]), 32'd0);
        chk("arst_ovf",  32'(ovf[0]), 32'd0);
        chk("arst_data", 32'(rxd[0]), 32'd0);
        chk("arst_abrt", 32'(abrt[0]), 32'd0);
        chk("arst_miso", 32'(miso0), 32'd0);
        cs[0] = 1'b1;
        clk_wait(2);
        reset_n = 1'b1;
        clk_wait(2);
        cs_lo(0);
        spi_word(0, 16'h0012, 8, 1'b0, got);
        chk("post_rst_echo", 32'(got), 32'h00);
        cs_hi(0);
        chk("post_rst_data", 32'(rxd[0]), 32'h12);
        chk("post_rst_lvl", 32'(lvl[0]), 32'd1);
        cs_lo(1);
        spi_word(1, 16'h005A, 8, 1'b0, got);
        chk("m3_rst_resp", 32'(got), 32'hC3);
        cs_hi(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
